// File: rtl/aes_sbox_sched_pkg.sv
// Shared crypto-unit package: scheduler state encoding and byte-lane helpers.
package aes_sbox_sched_pkg;

  localparam int WORD_W = 32;
  localparam int NBYTES = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [1:0] lowest_set(input logic [NBYTES-1:0] m);
    lowest_set = 2'd0;
    for (int k = NBYTES - 1; k >= 0; k--)
      if (m[k]) lowest_set = 2'(k);
  endfunction

endpackage

// File: rtl/aes_sbox_sched_sbox.sv
// Combinational forward AES S-box: one byte in, one byte out.
module aes_sbox_sched_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_sbox_sched.sv
// Shared S-box scheduler: arbitrates NREQ requesters onto one S-box, one byte per cycle.
// Define AES_SBOX_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module aes_sbox_sched
  import aes_sbox_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic [NREQ-1:0][WORD_W-1:0]  req_word_i,
  input  logic [NREQ-1:0][NBYTES-1:0]  req_mask_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [IDW-1:0]               resp_id_o,
  output logic [WORD_W-1:0]            resp_word_o,
  output logic                         busy_o
);

  sched_state_e              state_q, state_d;
  logic [NBYTES-1:0][7:0]    word_q, word_d;
  logic [NBYTES-1:0]         mask_q, mask_d;
  logic [IDW-1:0]            id_q, id_d;
  logic [NREQ-1:0]           gnt_vec;
  logic [IDW-1:0]            gnt_idx;
  logic [1:0]                byte_sel;
  logic [7:0]                sbox_in, sbox_out;
  logic                      hs;

`ifdef AES_SBOX_SCHED_RR_EN
  logic [IDW-1:0] last_q;

  always_comb begin : arb
    int  idx;
    logic found;
    gnt_vec = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req_valid_i[idx]) begin
        gnt_vec[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted handshake so a dropped valid keeps its turn.
  always_ff @(posedge clk) begin
    if (reset)   last_q <= IDW'(NREQ - 1);
    else if (hs) last_q <= gnt_idx;
  end
`else
  always_comb begin : arb
    logic found;
    gnt_vec = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid_i[i]) begin
        gnt_vec[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_vec[i]) gnt_idx = IDW'(i);
  end

  assign hs          = (state_q == IDLE) && (|gnt_vec);
  assign req_ready_o = (state_q == IDLE) ? gnt_vec : '0;

  // S-box only ever sees a byte of the latched word, never a requester input.
  assign byte_sel = lowest_set(mask_q);
  assign sbox_in  = word_q[byte_sel];

  aes_sbox_sched_sbox u_sbox (
    .in_i  (sbox_in),
    .out_o (sbox_out)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          word_d  = req_word_i[gnt_idx];
          mask_d  = req_mask_i[gnt_idx];
          id_d    = gnt_idx;
          state_d = (|req_mask_i[gnt_idx]) ? SUB : RESP;
        end
      end
      SUB: begin
        word_d[byte_sel] = sbox_out;
        mask_d[byte_sel] = 1'b0;
        if (mask_d == '0) state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      mask_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_word_o  = word_q;
  assign resp_id_o    = id_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for aes_sbox_sched against an S-box computed from GF(2^8) inversion.
module tb_aes_sbox_sched;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ-1:0][31:0]  req_word_i;
  logic [NREQ-1:0][3:0]   req_mask_i;
  logic                   resp_valid_o;
  logic                   resp_ready_i;
  logic [IDW-1:0]         resp_id_o;
  logic [31:0]            resp_word_o;
  logic                   busy_o;

  int vecs = 0;
  int errs = 0;
  logic [7:0] sref [256];

  always #5 clk = ~clk;

  aes_sbox_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_word_i   (req_word_i),
    .req_mask_i   (req_mask_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_id_o    (resp_id_o),
    .resp_word_o  (resp_word_o),
    .busy_o       (busy_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse then the AES affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) b = 8'(c);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++)
      if (m[k]) r[8*k +: 8] = sref[w[8*k +: 8]];
    return r;
  endfunction

  function automatic int popc(input logic [3:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    req_valid_i  = '0;
    req_word_i   = '0;
    req_mask_i   = '0;
    resp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issues one request and returns at the negedge where the response is first seen.
  task automatic run_one(input int r, input logic [31:0] w, input logic [3:0] m,
                         output int lat, output logic [31:0] rw,
                         output logic [IDW-1:0] rid, output bit to);
    int c;
    to = 1'b0;
    lat = 0;
    rw = '0;
    rid = '0;
    req_valid_i[r] = 1'b1;
    req_word_i[r]  = w;
    req_mask_i[r]  = m;
    c = 0;
    @(negedge clk);
    while (!req_ready_o[r] && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!req_ready_o[r]) begin
      to = 1'b1;
      req_valid_i[r] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_i[r] = 1'b0;
    req_word_i[r]  = ~w;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid_o && lat < 20);
    if (!resp_valid_o) to = 1'b1;
    rw  = resp_word_o;
    rid = resp_id_o;
    if (resp_ready_i) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vecs++;
    if ({req_ready_o, resp_valid_o, resp_id_o, resp_word_o, busy_o} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: ready=%b valid=%b id=%0d word=%h busy=%b, want all 0",
               req_ready_o, resp_valid_o, resp_id_o, resp_word_o, busy_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    int lat; logic [31:0] rw; logic [IDW-1:0] rid; bit to;
    run_one(0, 32'h00112233, 4'h1, lat, rw, rid, to);
    vecs++;
    if (to || rw !== 32'h001122C3 || rid !== 1'b0 || lat != 2) begin
      errs++;
      $display("FAIL req0_mask1: word=%h id=%0d lat=%0d to=%0d, want 001122c3 id 0 lat 2", rw, rid, lat, to);
    end
    run_one(0, 32'hDEADBEEF, 4'h0, lat, rw, rid, to);
    vecs++;
    if (to || rw !== 32'hDEADBEEF || rid !== 1'b0 || lat != 1) begin
      errs++;
      $display("FAIL mask0: word=%h id=%0d lat=%0d to=%0d, want deadbeef id 0 lat 1", rw, rid, lat, to);
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rw; logic [IDW-1:0] rid; bit to;
    resp_ready_i = 1'b0;
    run_one(1, 32'h53005300, 4'hF, lat, rw, rid, to);
    vecs++;
    if (to || rw !== 32'hED63ED63 || rid !== 1'b1 || lat != 5 || busy_o !== 1'b1) begin
      errs++;
      $display("FAIL req1_maskF: word=%h id=%0d lat=%0d busy=%b to=%0d, want ed63ed63 id 1 lat 5 busy 1",
               rw, rid, lat, busy_o, to);
    end
    req_valid_i[0] = 1'b1;
    req_mask_i[0]  = 4'h1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vecs++;
      if (resp_valid_o !== 1'b1 || resp_word_o !== 32'hED63ED63 || resp_id_o !== 1'b1 || req_ready_o !== '0) begin
        errs++;
        $display("FAIL hold_cycle%0d: valid=%b word=%h id=%0d ready=%b, want 1 ed63ed63 1 00",
                 c, resp_valid_o, resp_word_o, resp_id_o, req_ready_o);
      end
    end
    @(posedge clk);
    #1;
    req_valid_i[0] = 1'b0;
    resp_ready_i   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vecs++;
    if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL hold_release: valid=%b busy=%b, want 0 0", resp_valid_o, busy_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_arbitration();
    logic [31:0] w0, w1;
    logic [IDW-1:0] ids [4];
    logic [31:0] ws [4];
    int got;
    int exp_id;
    do_reset();
    w0 = $urandom;
    w1 = $urandom;
    req_word_i[0] = w0;
    req_word_i[1] = w1;
    req_mask_i[0] = 4'h3;
    req_mask_i[1] = 4'h3;
    req_valid_i   = 2'b11;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        ids[got] = resp_id_o;
        ws[got]  = resp_word_o;
        got++;
      end
    end
    @(posedge clk);
    #1;
    req_valid_i = '0;
    vecs++;
    if (got != 4) begin
      errs++;
      $display("FAIL arb_count: got %0d responses, want 4", got);
    end
    for (int i = 0; i < got; i++) begin
`ifdef AES_SBOX_SCHED_RR_EN
      exp_id = i % 2;
`else
      exp_id = 0;
`endif
      vecs++;
      if (int'(ids[i]) != exp_id || ws[i] !== model(exp_id == 0 ? w0 : w1, 4'h3)) begin
        errs++;
        $display("FAIL arb_order%0d: id=%0d word=%h, want id %0d word %h",
                 i, ids[i], ws[i], exp_id, model(exp_id == 0 ? w0 : w1, 4'h3));
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rw; logic [IDW-1:0] rid; bit to;
    bit seen;
    do_reset();
    req_valid_i[0] = 1'b1;
    req_word_i[0]  = 32'h01234567;
    req_mask_i[0]  = 4'hF;
    @(negedge clk);
    vecs++;
    if (req_ready_o !== 2'b01) begin
      errs++;
      $display("FAIL rstmid_grant: ready=%b, want 01", req_ready_o);
    end
    @(posedge clk);
    #1 req_valid_i[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vecs++;
    if ({req_ready_o, resp_valid_o, resp_id_o, resp_word_o, busy_o} !== '0) begin
      errs++;
      $display("FAIL rstmid_outputs: ready=%b valid=%b id=%0d word=%h busy=%b, want all 0",
               req_ready_o, resp_valid_o, resp_id_o, resp_word_o, busy_o);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid_o) seen = 1'b1;
    end
    vecs++;
    if (seen) begin
      errs++;
      $display("FAIL rstmid_no_resp: response seen=1 after reset, want 0");
    end
    @(posedge clk);
    #1;
    run_one(0, 32'h53005300, 4'h5, lat, rw, rid, to);
    vecs++;
    if (to || rw !== 32'h53635363 || rid !== 1'b0 || lat != 3) begin
      errs++;
      $display("FAIL rstmid_after: word=%h id=%0d lat=%0d to=%0d, want 53635363 id 0 lat 3", rw, rid, lat, to);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rw; logic [IDW-1:0] rid; bit to;
    int r;
    logic [31:0] w;
    logic [3:0] m;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(NREQ - 1, 0));
      w = $urandom;
      m = 4'($urandom);
      run_one(r, w, m, lat, rw, rid, to);
      vecs++;
      if (to || rw !== model(w, m) || int'(rid) != r || lat != popc(m) + 1) begin
        errs++;
        $display("FAIL rand%0d: req=%0d w=%h m=%h got word=%h id=%0d lat=%0d to=%0d, want %h id %0d lat %0d",
                 i, r, w, m, rw, rid, lat, to, model(w, m), r, popc(m) + 1);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) sref[a] = sbox_calc(8'(a));
    test_reset();
    test_vectors();
    test_hold();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
